potential_adder_sequencer: RTL and testbench



---
 rtl/potential_adder_sequencer.sv | 127 ++++++++++++
 tb/tb_potential_adder_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/potential_adder_sequencer.sv
// Per-timestep controller for the potential adder: walks every neuron, applies decay, drives the
// adder and stores the result. Optional SPIKE_VECTOR_EN adds a per-timestep spike bitmap output.
module potential_adder_sequencer #(
  parameter int unsigned NUM_NEURONS   = 30,
  parameter int unsigned NEURON_ID_W   = 5,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   wt_valid,
  output logic                   wt_ready,
  input  logic [31:0]            wt_data,
  output logic                   set_adder,
  output logic                   clear_adder,
  output logic [31:0]            input_weight,
  output logic [31:0]            decayed_potential,
  input  logic [31:0]            final_potential,
  input  logic                   spike,
  output logic                   spike_valid,
  output logic [NEURON_ID_W-1:0] spike_id,
  output logic                   busy,
`ifdef SPIKE_VECTOR_EN
  output logic [NUM_NEURONS-1:0] spike_vector,
`endif
  output logic                   done
);

  typedef enum logic [2:0] {
    StIdle, StClear, StLoad, StSet, StSettle, StCapture, StDone
  } state_e;

  state_e                 state_q;
  logic [NEURON_ID_W-1:0] idx_q;
  logic [3:0]             cnt_q;
  logic [31:0]            pot_q [NUM_NEURONS];

  // Halve a float by decrementing its exponent; denormal-range results flush to signed zero.
  function automatic logic [31:0] decay(input logic [31:0] x);
    logic [7:0] e;
    e = x[30:23];
    if (e == 8'd0 || e == 8'd1) return {x[31], 31'b0};
    else if (e == 8'hff)        return x;
    else                        return {x[31], e - 8'd1, x[22:0]};
  endfunction

  // Spike is reported in the CAPTURE cycle itself, so this path is combinational.
  assign spike_valid = (state_q == StCapture) && spike;
  assign spike_id    = spike_valid ? idx_q : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q           <= StIdle;
      idx_q             <= '0;
      cnt_q             <= '0;
      wt_ready          <= 1'b0;
      set_adder         <= 1'b0;
      clear_adder       <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      input_weight      <= '0;
      decayed_potential <= '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) pot_q[i] <= '0;
`ifdef SPIKE_VECTOR_EN
      spike_vector      <= '0;
`endif
    end else begin
      done      <= 1'b0;
      set_adder <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StClear;
            busy    <= 1'b1;
          end
        end
        StClear: begin
          idx_q       <= '0;
          clear_adder <= 1'b0;
          wt_ready    <= 1'b1;
          state_q     <= StLoad;
`ifdef SPIKE_VECTOR_EN
          spike_vector <= '0;
`endif
        end
        StLoad: begin
          if (wt_valid) begin
            input_weight      <= wt_data;
            decayed_potential <= decay(pot_q[idx_q]);
            wt_ready          <= 1'b0;
            set_adder         <= 1'b1;
            state_q           <= StSet;
          end
        end
        StSet: begin
          cnt_q   <= '0;
          state_q <= StSettle;
        end
        StSettle: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_q <= StCapture;
        end
        StCapture: begin
          pot_q[idx_q] <= final_potential;
`ifdef SPIKE_VECTOR_EN
          if (spike) spike_vector[idx_q] <= 1'b1;
`endif
          if (idx_q == NEURON_ID_W'(NUM_NEURONS - 1)) begin
            done        <= 1'b1;
            clear_adder <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q    <= idx_q + 1'b1;
            wt_ready <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_potential_adder_sequencer.sv
// Scoreboard bench for potential_adder_sequencer: a table-driven adder model, a weight feeder
// with injectable backpressure, and a monitor that checks set/spike/done events against queues.
module tb_potential_adder_sequencer;
  localparam int N = 30;
  localparam int S = 2;

  logic        CLK = 1'b0, RST = 1'b1, start = 1'b0, wt_valid = 1'b0;
  logic [31:0] wt_data = '0, final_potential = '0;
  logic        spike = 1'b0;
  logic        wt_ready, set_adder, clear_adder, spike_valid, busy, done;
  logic [31:0] input_weight, decayed_potential;
  logic [4:0]  spike_id;
`ifdef SPIKE_VECTOR_EN
  logic [N-1:0] spike_vector;
`endif

  potential_adder_sequencer #(.NUM_NEURONS(N), .NEURON_ID_W(5), .SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .start(start), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .wt_data(wt_data), .set_adder(set_adder), .clear_adder(clear_adder),
    .input_weight(input_weight), .decayed_potential(decayed_potential),
    .final_potential(final_potential), .spike(spike), .spike_valid(spike_valid),
    .spike_id(spike_id), .busy(busy),
`ifdef SPIKE_VECTOR_EN
    .spike_vector(spike_vector),
`endif
    .done(done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  logic [63:0] exp_set_q [$];
  int          exp_spk_q [$];
  int          exp_done_q [$];
  int          st_cyc = 0;
  bit          done_seen = 0;

  logic [31:0] w_tab [N];
  logic [31:0] fp_tab [N];
  logic        sp_tab [N];
  logic        noise_tab [N];
  int          nid = N, cur = 0, phase = -1;
  int          stall_at = -1, stall_left = 0;
  bit          in_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
  endtask

  // Adder model: result from table; spike from sp_tab only in CAPTURE, noise_tab in SET/SETTLE.
  always @(posedge CLK) begin
    #1;
    if (set_adder) begin
      cur   = (nid < N) ? nid : N - 1;
      nid   = nid + 1;
      phase = 0;
    end else if (phase >= 0) begin
      phase = (phase > S) ? -1 : phase + 1;
    end
    final_potential = fp_tab[cur];
    if (phase == S + 1)  spike = sp_tab[cur];
    else if (phase >= 0) spike = noise_tab[cur];
    else                 spike = 1'b0;
  end

  // Weight feeder with optional 5-cycle stall at neuron stall_at.
  always @(negedge CLK) begin
    if (in_stall) check("stall_ready", 32'(wt_ready), 32'd1);
    if (wt_ready && nid == stall_at && stall_left > 0) begin
      wt_valid = 1'b0;
      stall_left--;
      in_stall = 1;
      check("stall_no_set", 32'(set_adder), 32'd0);
    end else begin
      wt_valid = 1'b1;
      in_stall = 0;
    end
    wt_data = (nid < N) ? w_tab[nid] : 32'h0;
  end

  // Monitor
  always @(negedge CLK) begin
    if (set_adder) begin
      if (exp_set_q.size() == 0) unexpected("set_adder");
      else begin
        logic [63:0] e;
        e = exp_set_q.pop_front();
        check("input_weight", input_weight, e[63:32]);
        check("decayed_potential", decayed_potential, e[31:0]);
      end
    end
    if (spike_valid) begin
      if (exp_spk_q.size() == 0) unexpected("spike_valid");
      else check("spike_id", 32'(spike_id), 32'(exp_spk_q.pop_front()));
    end
    if (done) begin
      done_seen = 1;
      if (exp_done_q.size() == 0) unexpected("done");
      else check("latency", 32'(cyc - st_cyc), 32'(exp_done_q.pop_front()));
    end
  end

  function automatic logic [31:0] t1_dec(input int n);
    case (n)
      3:       return 32'h42200000;
      4:       return 32'h00000000;
      5:       return 32'hC1A00000;
      6:       return 32'h7F800000;
      8:       return 32'h80000000;
      9:       return 32'h00800000;
      10:      return 32'h7FC00001;
      default: return 32'h40A00000;
    endcase
  endfunction

  task automatic run_timestep(input int latency, input int extra_start_at);
    done_seen = 0;
    exp_done_q.push_back(latency);
    @(negedge CLK);
    nid = 0;
    @(negedge CLK);
    start  = 1'b1;
    st_cyc = cyc;
    for (int i = 0; i < 600 && !done_seen; i++) begin
      @(negedge CLK);
      start = (i == extra_start_at);
    end
    start = 1'b0;
    if (!done_seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within bound, expected latency %0d", latency);
    end
    @(negedge CLK);
    check("sets_left", 32'(exp_set_q.size()), 32'd0);
    check("spikes_left", 32'(exp_spk_q.size()), 32'd0);
    exp_done_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int n = 0; n < N; n++) begin
      w_tab[n] = '0; fp_tab[n] = '0; sp_tab[n] = 0; noise_tab[n] = 0;
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clear", 32'(clear_adder), 32'd1);
    check("rst_set", 32'(set_adder), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wt_ready", 32'(wt_ready), 32'd0);
    check("rst_spike_valid", 32'(spike_valid), 32'd0);
    RST = 1'b0;

    // T0: pots all zero; adder loads corner values for the next timestep's decay.
    for (int n = 0; n < N; n++) begin
      w_tab[n]  = 32'h41200000;
      fp_tab[n] = 32'h41200000;
      exp_set_q.push_back({32'h41200000, 32'h00000000});
    end
    fp_tab[3] = 32'h42A00000; fp_tab[4] = 32'h00800000; fp_tab[5] = 32'hC2200000;
    fp_tab[6] = 32'h7F800000; fp_tab[8] = 32'h80800000; fp_tab[9] = 32'h01000000;
    fp_tab[10] = 32'h7FC00001;
    run_timestep(2 + N * (3 + S), -1);

    // T1: decay corners, spikes at 3 and 29, spike noise outside CAPTURE, stall, stray start.
    for (int n = 0; n < N; n++) begin
      w_tab[n]  = 32'h40000000 | (32'(n) << 16);
      fp_tab[n] = 32'h41200000;
      exp_set_q.push_back({w_tab[n], t1_dec(n)});
    end
    sp_tab[3] = 1; sp_tab[29] = 1; noise_tab[1] = 1;
    exp_spk_q.push_back(3);
    exp_spk_q.push_back(29);
    stall_at = 7; stall_left = 5;
    run_timestep(2 + N * (3 + S) + 5, 60);
    sp_tab[3] = 0; sp_tab[29] = 0; noise_tab[1] = 0; stall_at = -1;

    // T2: abort with RST during neuron 12 SETTLE.
    for (int n = 0; n < N; n++) begin
      w_tab[n]  = 32'h41200000;
      fp_tab[n] = 32'h42000000;
    end
    for (int n = 0; n <= 12; n++) exp_set_q.push_back({32'h41200000, 32'h40A00000});
    done_seen = 0;
    @(negedge CLK);
    nid = 0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 200 && !(nid == 13 && phase == 1); i++) @(negedge CLK);
    check("abort_reached", 32'(nid == 13 && phase == 1), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_clear", 32'(clear_adder), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    repeat (10) @(negedge CLK);
    check("abort_sets_left", 32'(exp_set_q.size()), 32'd0);
    check("abort_no_done", 32'(done_seen), 32'd0);

    // Start in the same cycle as RST must be dropped.
    RST = 1'b1; start = 1'b1;
    @(negedge CLK);
    RST = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    check("rst_start_busy2", 32'(busy), 32'd0);
    check("rst_start_clear", 32'(clear_adder), 32'd1);

    // T3: full timestep from neuron 0 with zeroed potentials.
    for (int n = 0; n < N; n++) begin
      w_tab[n] = 32'h3F800000;
      exp_set_q.push_back({32'h3F800000, 32'h00000000});
    end
    run_timestep(2 + N * (3 + S), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
